// File: rtl/rv_wb_writer_pkg.sv
// Shared constants for the RV32I writeback writer: result-source codes,
// load funct3 codes and the writer FSM encoding.
package rv_wb_writer_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] WB_SRC_ALU  = 2'd0;
  localparam logic [1:0] WB_SRC_LOAD = 2'd1;
  localparam logic [1:0] WB_SRC_PC4  = 2'd2;
  localparam logic [1:0] WB_SRC_RSVD = 2'd3;

  localparam logic [2:0] LD_F3_LB  = 3'b000;
  localparam logic [2:0] LD_F3_LH  = 3'b001;
  localparam logic [2:0] LD_F3_LW  = 3'b010;
  localparam logic [2:0] LD_F3_LBU = 3'b100;
  localparam logic [2:0] LD_F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_ST_IDLE    = 2'd0,
    WB_ST_WAIT_LD = 2'd1,
    WB_ST_WRITE   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/rv_load_ext.sv
// Load extraction: picks the byte/half addressed by addr_lo out of a raw
// aligned word and sign- or zero-extends it according to funct3.
module rv_load_ext
  import rv_wb_writer_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] raw_i,
  output logic [XLEN-1:0] ext_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Halfword selection uses only addr_lo[1]; a misaligned LH is not trapped here.
  assign byte_v = raw_i[{addr_lo_i, 3'b000} +: 8];
  assign half_v = raw_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: assigning a default before the case keeps this purely
    // combinational; any path leaving ext_o unassigned would infer a latch.
    ext_o = raw_i;
    case (funct3_i)
      LD_F3_LB:  ext_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      LD_F3_LH:  ext_o = {{(XLEN-16){half_v[15]}}, half_v};
      LD_F3_LW:  ext_o = raw_i;
      LD_F3_LBU: ext_o = {{(XLEN-8){1'b0}}, byte_v};
      LD_F3_LHU: ext_o = {{(XLEN-16){1'b0}}, half_v};
      default:   ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/rv_wb_writer.sv
// Writeback writer: accepts retiring instructions, waits for late load data,
// drives the register-file write port and the forwarding bus.
// Optional retired-instruction counter enabled by `define RV_WB_INSTRET_EN.
module rv_wb_writer
  import rv_wb_writer_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            i_wb_clk,
  input  logic            i_wb_rst,
  input  logic            i_wb_valid,
  output logic            o_wb_ready,
  input  logic [4:0]      i_wb_rd,
  input  logic            i_wb_rd_we,
  input  logic [1:0]      i_wb_src,
  input  logic [XLEN-1:0] i_wb_alu_res,
  input  logic [XLEN-1:0] i_wb_pc4,
  input  logic [2:0]      i_wb_funct3,
  input  logic [1:0]      i_wb_addr_lo,
  input  logic            i_wb_ld_valid,
  input  logic [XLEN-1:0] i_wb_ld_data,
  output logic            o_wb_rf_we,
  output logic [4:0]      o_wb_rf_wa,
  output logic [XLEN-1:0] o_wb_rf_wd,
  output logic            o_wb_fwd_valid,
  output logic [4:0]      o_wb_fwd_rd,
  output logic [XLEN-1:0] o_wb_fwd_data,
  output logic [63:0]     o_wb_instret
);

  wb_state_e       state_q;
  logic [4:0]      rd_q;
  logic            rd_we_q;
  logic [2:0]      funct3_q;
  logic [1:0]      addr_lo_q;
  logic            rf_we_q;
  logic [4:0]      rf_wa_q;
  logic [XLEN-1:0] rf_wd_q;

  logic            accept;
  logic            ld_done;
  logic [2:0]      ext_funct3;
  logic [1:0]      ext_addr_lo;
  logic [XLEN-1:0] ext_val;
  logic            wr_d;
  logic [4:0]      wr_rd_d;
  logic            wr_we_d;
  logic [XLEN-1:0] wr_wd_d;

  assign o_wb_ready = (state_q != WB_ST_WAIT_LD);
  assign accept     = i_wb_valid && o_wb_ready;
  assign ld_done    = (state_q == WB_ST_WAIT_LD) && i_wb_ld_valid;

  // While waiting, the extractor works on the latched load type; otherwise on
  // the incoming one (same-cycle response).
  assign ext_funct3  = (state_q == WB_ST_WAIT_LD) ? funct3_q  : i_wb_funct3;
  assign ext_addr_lo = (state_q == WB_ST_WAIT_LD) ? addr_lo_q : i_wb_addr_lo;

  rv_load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3_i  (ext_funct3),
    .addr_lo_i (ext_addr_lo),
    .raw_i     (i_wb_ld_data),
    .ext_o     (ext_val)
  );

  // Decide whether the next cycle is a WRITE cycle and what it writes.
  always_comb begin
    wr_d    = 1'b0;
    wr_rd_d = rd_q;
    wr_we_d = rd_we_q;
    wr_wd_d = ext_val;
    if (ld_done) begin
      wr_d = 1'b1;
    end else if (accept && (i_wb_src != WB_SRC_LOAD || i_wb_ld_valid)) begin
      wr_d    = 1'b1;
      wr_rd_d = i_wb_rd;
      wr_we_d = i_wb_rd_we;
      case (i_wb_src)
        WB_SRC_LOAD: wr_wd_d = ext_val;
        WB_SRC_PC4:  wr_wd_d = i_wb_pc4;
        WB_SRC_ALU,
        WB_SRC_RSVD: wr_wd_d = i_wb_alu_res;
        default:     wr_wd_d = i_wb_alu_res;
      endcase
    end
  end

  always_ff @(posedge i_wb_clk) begin
    // NOTE: non-blocking assignments so every register here samples the
    // pre-edge values, independent of statement order.
    if (i_wb_rst) begin
      state_q   <= WB_ST_IDLE;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      rf_we_q   <= 1'b0;
      rf_wa_q   <= '0;
      rf_wd_q   <= '0;
    end else begin
      rf_we_q <= wr_d && wr_we_d && (wr_rd_d != 5'd0);
      if (accept) begin
        rd_q      <= i_wb_rd;
        rd_we_q   <= i_wb_rd_we;
        funct3_q  <= i_wb_funct3;
        addr_lo_q <= i_wb_addr_lo;
      end
      if (wr_d) begin
        state_q <= WB_ST_WRITE;
        rf_wa_q <= wr_rd_d;
        rf_wd_q <= wr_wd_d;
      end else if (accept) begin
        state_q <= WB_ST_WAIT_LD;
      end else if (state_q != WB_ST_WAIT_LD) begin
        state_q <= WB_ST_IDLE;
      end
    end
  end

  assign o_wb_rf_we     = rf_we_q;
  assign o_wb_rf_wa     = rf_wa_q;
  assign o_wb_rf_wd     = rf_wd_q;
  assign o_wb_fwd_valid = rf_we_q;
  assign o_wb_fwd_rd    = rf_wa_q;
  assign o_wb_fwd_data  = rf_wd_q;

`ifdef RV_WB_INSTRET_EN
  logic [63:0] instret_q;

  // Counts every WRITE cycle, including x0 and rd_we=0 retirements.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      instret_q <= '0;
    end else if (state_q == WB_ST_WRITE) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign o_wb_instret = instret_q;
`else
  assign o_wb_instret = '0;
`endif

endmodule
